// File: rtl/register_write_arbiter.sv
// register_write_arbiter: round-robin arbiter feeding one enable-loaded register, one write per two cycles.
// Optional ARB_LOCK_EN adds i_req_lock so a locked requester keeps priority for up to MAX_HOLD grants.
module register_write_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [NUM_REQ-1:0]          i_req,
   input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
`ifdef ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]          i_req_lock,
`endif
   output logic [NUM_REQ-1:0]          o_ack,
   output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
   output logic                        o_reg_enable,
   output logic [DATA_W-1:0]           o_reg_in,
   output logic                        o_busy
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic {S_IDLE, S_GRANT} state_t;
   state_t r_state, w_next;
   logic [IW-1:0] r_rr_ptr, w_win, w_win_inc, w_ptr_nxt;
   logic [IW-1:0] w_idx [NUM_REQ];
   logic w_take;
   // w_idx[k] is the requester k places after the pointer, already wrapped into range
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_idx
      assign w_idx[g] = IW'((int'(r_rr_ptr) + g) % NUM_REQ);
   end
   always_comb begin
      w_win = r_rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (i_req[w_idx[k]]) w_win = w_idx[k];
   end
   assign w_take    = (r_state == S_IDLE) && |i_req;
   assign w_win_inc = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
`ifdef ARB_LOCK_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] r_hold, w_hold_inc;
   logic w_keep;
   assign w_hold_inc = ((w_win == o_grant_id) ? r_hold : '0) + 1'b1;
   assign w_keep     = i_req_lock[w_win] && (w_hold_inc < HW'(MAX_HOLD));
   assign w_ptr_nxt  = w_keep ? w_win : w_win_inc;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_hold <= '0;
      else if (w_take) r_hold <= w_keep ? w_hold_inc : '0;
`else
   assign w_ptr_nxt = w_win_inc;
`endif
   always_comb w_next = w_take ? S_GRANT : S_IDLE;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   // reg_in and grant_id keep the last grant's value after the pulse ends
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_rr_ptr     <= '0;
         o_ack        <= '0;
         o_grant_id   <= '0;
         o_reg_enable <= 1'b0;
         o_reg_in     <= '0;
         o_busy       <= 1'b0;
      end else if (w_take) begin
         r_rr_ptr     <= w_ptr_nxt;
         o_ack        <= NUM_REQ'(1) << w_win;
         o_grant_id   <= w_win;
         o_reg_enable <= 1'b1;
         o_reg_in     <= DATA_W'(i_req_data >> (DATA_W * w_win));
         o_busy       <= 1'b1;
      end else begin
         o_ack        <= '0;
         o_reg_enable <= 1'b0;
         o_busy       <= 1'b0;
      end
endmodule
